shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Command-driven sequencer for the team's serial left/right shift-register datapath (serial din, direction select l, serial dout).
- Accepts a parallel word, bit count and direction over a valid/ready command port.
- Serialises the word into the shift register, flushes the pipeline, and reassembles the bits returned on dout into a parallel response word.
- Sits between a bus-side master and one shift-register instance, which it owns exclusively.

Parameters:
WIDTH, 8, width of command/response data words
LEN_W, 4, width of cmd_len; must satisfy 2^LEN_W > WIDTH
SR_DEPTH, 4, din-to-dout latency of the attached register in enabled shift cycles

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command
cmd_dir  input  1  direction: 0 = left (sr_l=0), 1 = right (sr_l=1)
cmd_len  input  LEN_W  number of bits to shift
cmd_data  input  WIDTH  word to serialise
sr_din  output  1  serial data to register
sr_l  output  1  direction select to register
sr_en  output  1  shift strobe; register advances only on cycles with sr_en=1
sr_dout  input  1  serial data from register
rsp_valid  output  1  response word available
rsp_ready  input  1  response consumed
rsp_data  output  WIDTH  reassembled word
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE. Outputs cmd_ready=1, sr_din=0, sr_l=0, sr_en=0, rsp_valid=0, rsp_data=0, busy=0. Internal counters and shadow registers are cleared. Reset overrides any state, including mid-shift; no response is produced for an interrupted command.
- FSM states are IDLE, SHIFT, FLUSH and DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch data, dir and eff_len = min(cmd_len, WIDTH); clear k and rsp_data.
  - If eff_len=0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - sr_en=1, sr_din = data[k], where k is the enabled-cycle index starting at 0.
  - Stay for eff_len cycles, then go to FLUSH.
- FLUSH:
  - sr_en=1, sr_din=0.
  - Stay for SR_DEPTH cycles, then go to DONE.
- Capture rule, applied in SHIFT and FLUSH:
  - On each enabled cycle with k ≥ SR_DEPTH and (k−SR_DEPTH) < eff_len, set rsp_data[k−SR_DEPTH] = sr_dout.
  - Bits at index eff_len..WIDTH−1 remain 0.
- sr_l holds the latched dir from acceptance until DONE exits, and must not change while sr_en can be 1.
- DONE:
  - rsp_valid=1, and rsp_data is stable.
  - On rsp_ready=1, go to IDLE. rsp_valid falls on the next cycle.
- cmd_ready=0 in all states other than IDLE. Commands are not queued.
- Latency: with acceptance at cycle T0, sr_en is high for cycles T0+1 .. T0+eff_len+SR_DEPTH. rsp_valid first asserts at T0+eff_len+SR_DEPTH+1.
- Boundaries:
  - cmd_len > WIDTH is clamped to WIDTH.
  - cmd_len=0 produces no sr_en pulse; rsp_valid asserts at T0+1 with rsp_data=0.
  - rsp_ready held high already in DONE gives a single-cycle rsp_valid.
  - Back-to-back commands require at least one IDLE cycle between them.

Optional Feature:
- Macro SHIFT_SEQ_CTRL_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output rsp_aborted (1 bit, reset 0).
  - abort=1 in SHIFT or FLUSH: next state is DONE, sr_en drops the next cycle, rsp_aborted=1, and rsp_data keeps the bits captured so far.
  - abort is ignored in IDLE and DONE.
  - rsp_aborted clears on leaving DONE.
- When undefined: neither port exists, and every started command runs to completion.

Test Plan:
- Bench setup: WIDTH=8, SR_DEPTH=4; the bench models the register as a 4-stage delay line advancing on sr_en.
- cmd_data=8'hA5, len=8, dir=0, accepted at T0 -> sr_en high T0+1..T0+12, sr_l=0 throughout, rsp_valid at T0+13, rsp_data=8'hA5, busy=1 T0+1..T0+13.
- cmd_data=8'hFF, len=3, dir=1 -> sr_l=1, sr_en high 7 cycles, rsp_data=8'h07.
- cmd_len=0 -> no sr_en pulse, rsp_valid at T0+1, rsp_data=8'h00.
- cmd_len=12 with data 8'h3C -> clamped: 12 enabled cycles, rsp_data=8'h3C. rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable and cmd_ready=0 throughout.
- reset=0 at T0+5 of an 8-bit command -> next cycle sr_en=0, rsp_valid=0, cmd_ready=1. A following command 8'h5A completes with rsp_data=8'h5A.
- Macro defined: abort at T0+6 during 8'hA5 len=8 -> DONE at T0+7, rsp_aborted=1, rsp_data=8'h01 (bits 0-1 captured).

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serialises a command word through the shift register and reassembles dout into a response
// Optional abort port pair enabled by SHIFT_SEQ_CTRL_ABORT_EN
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int SR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_din,
  output logic             sr_l,
  output logic             sr_en,
  input  logic             sr_dout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             rsp_aborted
`endif
);
  localparam int KW = $clog2(WIDTH + SR_DEPTH + 1);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] data;
  logic [KW-1:0] len, k, k_nxt, cap_k, eff_len;
  logic [IW-1:0] cap_i;
  logic cap_en, stop;
  // the register output lags din by SR_DEPTH enabled cycles, so bit k-SR_DEPTH arrives now
  always_comb begin
    eff_len = cmd_len > LEN_W'(WIDTH) ? KW'(WIDTH) : KW'(cmd_len);
    k_nxt = k + KW'(1);
    cap_k = k - KW'(SR_DEPTH);
    cap_en = k >= KW'(SR_DEPTH) && cap_k < len;
    cap_i = cap_k[IW-1:0];
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    stop = abort;
`else
    stop = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      data <= '0;
      len <= '0;
      k <= '0;
      cmd_ready <= 1'b1;
      sr_din <= 1'b0;
      sr_l <= 1'b0;
      sr_en <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      busy <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
      rsp_aborted <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          data <= cmd_data >> 1;
          len <= eff_len;
          k <= '0;
          rsp_data <= '0;
          sr_l <= cmd_dir;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          sr_en <= eff_len != '0;
          sr_din <= eff_len != '0 && cmd_data[0];
          rsp_valid <= eff_len == '0;
          state <= eff_len == '0 ? DONE : SHIFT;
        end
        SHIFT, FLUSH: begin
          if (cap_en) rsp_data[cap_i] <= sr_dout;
          k <= k_nxt;
          data <= data >> 1;
          if (stop || k_nxt == len + KW'(SR_DEPTH)) begin
            state <= DONE;
            sr_en <= 1'b0;
            sr_din <= 1'b0;
            rsp_valid <= 1'b1;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
            rsp_aborted <= stop;
`endif
          end else begin
            state <= k_nxt < len ? SHIFT : FLUSH;
            sr_din <= k_nxt < len && data[0];
          end
        end
        DONE: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy <= 1'b0;
          sr_l <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
          rsp_aborted <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl with a delay-line model of the shift register
module tb_shift_seq_ctrl;
  localparam int W = 8, LW = 4, D = 4;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_dir = 0, rsp_ready = 0;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0] cmd_data = '0;
  logic cmd_ready, sr_din, sr_l, sr_en, sr_dout, rsp_valid, busy;
  logic [W-1:0] rsp_data;
  logic [D-1:0] dl = '0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic abort = 0, rsp_aborted;
`endif
  typedef struct {int d; int dir; int en; int lat; int ab;} exp_t;
  exp_t sb[$];
  int nvec = 0, nerr = 0;
  int t = 0, en_cnt = 0, first_v = 0;
  bit active = 0, post = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (sr_en) dl <= {dl[D-2:0], sr_din};
  assign sr_dout = dl[D-1];

  shift_seq_ctrl #(.WIDTH(W), .LEN_W(LW), .SR_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .sr_din(sr_din), .sr_l(sr_l), .sr_en(sr_en), .sr_dout(sr_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    , .abort(abort), .rsp_aborted(rsp_aborted)
`endif
  );

  task automatic chk(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  // monitor: tracks one command from acceptance to response handshake
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      active = 0;
      post = 0;
    end else begin
      if (post) begin
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        chk("busy_clear", busy, 0);
        post = 0;
      end
      if (cmd_valid && cmd_ready) begin
        active = 1;
        t = 0;
        en_cnt = 0;
        first_v = 0;
      end else if (active && sb.size() > 0) begin
        t++;
        chk("busy", busy, 1);
        chk("cmd_ready_low", cmd_ready, 0);
        if (sr_en) begin
          en_cnt++;
          chk("sr_l", sr_l, sb[0].dir);
        end
        if (rsp_valid) begin
          if (first_v == 0) begin
            first_v = t;
            chk("latency", t, sb[0].lat);
          end
          chk("rsp_data", rsp_data, sb[0].d);
          if (rsp_ready) begin
            chk("sr_en_cycles", en_cnt, sb[0].en);
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
            chk("rsp_aborted", rsp_aborted, sb[0].ab > 0 ? 1 : 0);
`endif
            void'(sb.pop_front());
            active = 0;
            post = 1;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input int len, input int dir, input int ab);
    int eff, capn;
    exp_t e;
    int to = 0;
    while (!cmd_ready && to < 50) begin @(posedge clk); #1; to++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    eff = len > W ? W : len;
    capn = ab > 0 ? (ab - D < 0 ? 0 : (ab - D > eff ? eff : ab - D)) : eff;
    e.d = d & ((1 << capn) - 1);
    e.dir = dir;
    e.en = ab > 0 ? ab : eff + D * (eff > 0 ? 1 : 0);
    e.lat = e.en + 1;
    e.ab = ab;
    sb.push_back(e);
    cmd_valid = 1;
    cmd_data = W'(d);
    cmd_len = LW'(len);
    cmd_dir = dir[0];
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_data = W'($urandom);
    cmd_len = LW'($urandom);
    cmd_dir = 1'($urandom);
  endtask

  task automatic run(input int d, input int len, input int dir, input int rdly, input int ab);
    int to = 0;
    rsp_ready = (rdly == 0);
    issue(d, len, dir, ab);
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    if (ab > 0) begin
      repeat (ab - 1) begin @(posedge clk); #1; end
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
    end
`endif
    while (!rsp_valid && to < 64) begin @(posedge clk); #1; to++; end
    chk("rsp_seen", rsp_valid, 1);
    repeat (rdly) begin @(posedge clk); #1; end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eff, ab;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_sr_en", sr_en, 0);
    chk("rst_sr_din", sr_din, 0);
    chk("rst_sr_l", sr_l, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    run(8'hA5, 8, 0, 2, 0);
    run(8'hFF, 3, 1, 0, 0);
    run(8'h6C, 0, 0, 1, 0);
    run(8'h3C, 12, 0, 5, 0);
    // reset in the middle of a command, then a clean command
    rsp_ready = 0;
    issue(8'hC3, 8, 1, 0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 0;
    @(posedge clk); #1;
    chk("midrst_sr_en", sr_en, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    reset = 1;
    @(posedge clk); #1;
    run(8'h5A, 8, 0, 0, 0);
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    run(8'hA5, 8, 0, 0, 6);
    run(8'h96, 5, 1, 1, 2);
`endif
    for (int i = 0; i < 24; i++) begin
      eff = 0;
      ab = 0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
      eff = 1;
`endif
      if (eff == 1) begin
        eff = $urandom_range(1, W);
        ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, eff + D) : 0;
        run($urandom_range(0, 255), eff, $urandom_range(0, 1), $urandom_range(0, 3), ab);
      end else begin
        run($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3), 0);
      end
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
